wb_regfile: RTL
===============

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; reset  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-002 control_wb_in  input  2  writeback control from MEM/WB: bit1 = RegWrite, bit0 = MemtoReg.
REQ-003 read_data_in  input  32  data-memory load value from MEM/WB.
REQ-004 alu_result_in  input  32  ALU result from MEM/WB.
REQ-005 write_reg_in  input  5  destination register number from MEM/WB.
REQ-006 read_reg1, read_reg2  input  5 each  decode-stage source register numbers.
REQ-007 read_data1, read_data2  output  32 each  source operand values.
REQ-008 wb_data  output  32  selected writeback value (combinational).
REQ-009 wb_write  output  1  effective write strobe (combinational).
REQ-010 write_count  output  32  count of committed register writes.

Function
REQ-011 wb_data SHALL be read_data_in when MemtoReg=1, else alu_result_in; no latency.
REQ-012 wb_write SHALL be 1 only when RegWrite=1 and write_reg_in != 0.
REQ-013 Storage SHALL be 31 x 32-bit registers for r1..r31; r0 SHALL always read 0 and SHALL never be written.
REQ-014 On each rising clk edge with wb_write=1, register[write_reg_in] SHALL take wb_data; otherwise all registers SHALL hold.
REQ-015 read_data1/read_data2 SHALL be combinational reads of register[read_reg1]/register[read_reg2], subject to REQ-022.
REQ-016 Both read ports SHALL operate independently; the same register MAY be selected on both ports, and both ports then return the same value.
REQ-017 write_count SHALL increment by 1 on each rising edge with wb_write=1, wrap from 0xFFFFFFFF to 0, and hold otherwise.
REQ-018 RegWrite=1 with write_reg_in=0 SHALL not change state and SHALL not increment write_count.
REQ-019 When MemtoReg=1 and RegWrite=0, the block SHALL not write; wb_data SHALL still show read_data_in.

Reset
REQ-020 When reset=0, all registers and write_count SHALL clear to 0 immediately, without waiting for a clk edge; read_data1/read_data2 SHALL read 0 at once.
REQ-021 While reset=0, writes SHALL be blocked. The first write after deassertion SHALL take effect on the first rising edge where reset=1 and wb_write=1. Asserting reset mid-sequence SHALL discard all earlier writes.

Configuration
REQ-022 Macro WB_BYPASS_EN:
- Defined: when wb_write=1 and read_regN == write_reg_in (N = 1, 2), read_dataN SHALL return wb_data in the same cycle (write-before-read).
- Undefined: read_dataN SHALL return the stored value, and the new value SHALL become visible only after the clk edge.
- In both builds, r0 SHALL read 0 and reset behaviour SHALL be unchanged.

Verification
REQ-023 Reset: hold reset=0, then read r1, r31 and write_count -> all read 0x00000000; apply a write with reset=0 -> no change.
REQ-024 ALU writeback: control=2'b10, alu=0x12345678, write_reg=5 for one edge -> r5=0x12345678, write_count=1; read_reg1=5 returns 0x12345678.
REQ-025 Load writeback: control=2'b11, read_data=0xA5A5A5A5, alu=0x87654321, write_reg=21 -> r21=0xA5A5A5A5, wb_data=0xA5A5A5A5 before the edge.
REQ-026 r0 and no-write cases:
- control=2'b11, write_reg=0, data=0xFFFFFFFF -> r0 reads 0, write_count unchanged.
- control=2'b01, write_reg=10 -> r10 unchanged, wb_write=0.
REQ-027 Bypass: r10=0x11111111; apply control=2'b10, alu=0x55555555, write_reg=10, read_reg2=10 before the edge -> read_data2=0x55555555 with WB_BYPASS_EN, 0x11111111 without; both builds read 0x55555555 after the edge.
REQ-028 Async reset mid-run: after REQ-024/REQ-025, pull reset low between clk edges -> r5, r21 and write_count read 0 within the same cycle; after release, a write to r31 of 0x0000FFFF -> r31=0x0000FFFF, write_count=1.

Source files
------------

// File: rtl/wb_regfile_if.sv
// ============================================================================
// Module   : wb_regfile_if
// Brief    : Writeback/decode bus bundle for the wb_regfile register file.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface wb_regfile_if;
    logic [1:0]  control_wb_in;   // bit1 = RegWrite, bit0 = MemtoReg
    logic [31:0] read_data_in;
    logic [31:0] alu_result_in;
    logic [4:0]  write_reg_in;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] wb_data;
    logic        wb_write;
    logic [31:0] write_count;

    modport master (
        output control_wb_in, read_data_in, alu_result_in, write_reg_in,
               read_reg1, read_reg2,
        input  read_data1, read_data2, wb_data, wb_write, write_count
    );

    modport slave (
        input  control_wb_in, read_data_in, alu_result_in, write_reg_in,
               read_reg1, read_reg2,
        output read_data1, read_data2, wb_data, wb_write, write_count
    );
endinterface

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
// Module   : wb_regfile
// Brief    : 31x32 register file with writeback mux, r0 hard-wired to zero
//            and committed-write counter. Optional macro WB_BYPASS_EN adds
//            same-cycle write-to-read forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_regfile (
    input  wire logic   clk,
    input  wire logic   reset,      // asynchronous, active low
    wb_regfile_if.slave bus
);

    localparam int c_NREGS = 32;

    logic [31:0] r_regs [1:c_NREGS-1];
    logic [31:0] r_write_count;

    logic [31:0] w_wb_data;
    logic        w_wb_write;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;

    assign w_wb_data  = bus.control_wb_in[0] ? bus.read_data_in : bus.alu_result_in;
    assign w_wb_write = bus.control_wb_in[1] && (bus.write_reg_in != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < c_NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_write_count <= '0;
        end else if (w_wb_write) begin
            r_regs[bus.write_reg_in] <= w_wb_data;
            r_write_count            <= r_write_count + 32'd1;
        end
    end

    // Forwarding is suppressed while reset is held so reads stay zero.
    always_comb begin
        w_rd1 = '0;
        if (bus.read_reg1 != 5'd0) begin
            w_rd1 = r_regs[bus.read_reg1];
        end
`ifdef WB_BYPASS_EN
        if (reset && w_wb_write && (bus.read_reg1 == bus.write_reg_in)) begin
            w_rd1 = w_wb_data;
        end
`endif
    end

    always_comb begin
        w_rd2 = '0;
        if (bus.read_reg2 != 5'd0) begin
            w_rd2 = r_regs[bus.read_reg2];
        end
`ifdef WB_BYPASS_EN
        if (reset && w_wb_write && (bus.read_reg2 == bus.write_reg_in)) begin
            w_rd2 = w_wb_data;
        end
`endif
    end

    assign bus.read_data1  = w_rd1;
    assign bus.read_data2  = w_rd2;
    assign bus.wb_data     = w_wb_data;
    assign bus.wb_write    = w_wb_write;
    assign bus.write_count = r_write_count;

endmodule

`default_nettype wire
